// File: rtl/key_scan_encoder.sv
// Keypad encoder: synchronises N active-low key lines, picks the highest pressed index,
// debounces it, and emits press / auto-repeat events through a one-entry valid/ready buffer.
//
// state          | meaning
// ST_RELEASED    | no stable key; waiting for GS to rise
// ST_HELD_DELAY  | key held; timer counts down to the first repeat
// ST_HELD_REPEAT | key held; timer counts down between later repeats
module key_scan_encoder #(
  parameter int N_KEYS        = 10,
  parameter int CODE_W        = $clog2(N_KEYS),
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] S_n,
  output logic [CODE_W-1:0] L,
  output logic              GS,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code,
  input  logic              evt_ready,
  output logic              ovf,
  input  logic              ovf_clr
);

  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int T_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
  localparam logic [TW-1:0]    T_DELAY  = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0]    T_PERIOD = TW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_RELEASED    = 2'd0,
    ST_HELD_DELAY  = 2'd1,
    ST_HELD_REPEAT = 2'd2
  } state_t;

  logic [N_KEYS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic              cand_any;
  logic [CODE_W-1:0] cand_code;
  logic              cand_any_q, cand_any_d;
  logic [CODE_W-1:0] cand_code_q, cand_code_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stab_gs_q, stab_gs_d;
  logic [CODE_W-1:0] stab_code_q, stab_code_d;
  logic              stab_upd;
  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ev_new;
  logic              evt_valid_q, evt_valid_d;
  logic [CODE_W-1:0] evt_code_q, evt_code_d;
  logic              ovf_q, ovf_d;

  // Highest-index pressed key wins.
  always_comb begin
    cand_any  = ~&sync2_q;
    cand_code = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (!sync2_q[i]) cand_code = CODE_W'(i);
    end
  end

  always_comb begin
    sync1_d     = S_n;
    sync2_d     = sync1_q;
    cand_any_d  = cand_any;
    cand_code_d = cand_code;

    if ({cand_any, cand_code} != {cand_any_q, cand_code_q}) cnt_d = '0;
    else if (cnt_q != DB_LAST)                                cnt_d = cnt_q + CNT_W'(1);
    else                                                      cnt_d = cnt_q;

    stab_upd    = (cnt_q == DB_LAST) &&
                  ({cand_any_q, cand_code_q} != {stab_gs_q, stab_code_q});
    stab_gs_d   = stab_upd ? cand_any_q  : stab_gs_q;
    stab_code_d = stab_upd ? cand_code_q : stab_code_q;
  end

  // Key FSM acts on the next stable state so the press event lands with L/GS.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    ev_new  = 1'b0;
    case (state_q)
      ST_RELEASED: begin
        if (stab_gs_d) begin
          ev_new  = 1'b1;
          timer_d = T_DELAY;
          state_d = ST_HELD_DELAY;
        end
      end
      ST_HELD_DELAY, ST_HELD_REPEAT: begin
        if (!stab_gs_d) begin
          state_d = ST_RELEASED;
        end else if (stab_code_d != stab_code_q) begin
          ev_new  = 1'b1;
          timer_d = T_DELAY;
          state_d = ST_HELD_DELAY;
        end else if (timer_q != '0) begin
          timer_d = timer_q - TW'(1);
        end else if (state_q == ST_HELD_REPEAT || REPEAT_EN != 0) begin
          ev_new  = 1'b1;
          timer_d = T_PERIOD;
          state_d = ST_HELD_REPEAT;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_code_d  = evt_code_q;
    ovf_d       = ovf_q & ~ovf_clr;
    if (ev_new) begin
      if (!evt_valid_q || evt_ready) begin
        evt_valid_d = 1'b1;
        evt_code_d  = stab_code_d;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      cand_any_q  <= 1'b0;
      cand_code_q <= '0;
      cnt_q       <= '0;
      stab_gs_q   <= 1'b0;
      stab_code_q <= '0;
      state_q     <= ST_RELEASED;
      timer_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_code_q  <= '0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cand_any_q  <= cand_any_d;
      cand_code_q <= cand_code_d;
      cnt_q       <= cnt_d;
      stab_gs_q   <= stab_gs_d;
      stab_code_q <= stab_code_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      evt_valid_q <= evt_valid_d;
      evt_code_q  <= evt_code_d;
      ovf_q       <= ovf_d;
    end
  end

  assign L         = stab_code_q;
  assign GS        = stab_gs_q;
  assign evt_valid = evt_valid_q;
  assign evt_code  = evt_code_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_key_scan_encoder.sv
// Bench for key_scan_encoder: edge-level reference model with a scoreboard queue of
// expected event codes, directed keypad scenarios followed by randomised traffic.
module tb_key_scan_encoder;

  localparam int N      = 10;
  localparam int CW     = $clog2(N);
  localparam int DB     = 4;
  localparam int REP_EN = 1;
  localparam int DELAY  = 20;
  localparam int PERIOD = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  S_n;
  logic [CW-1:0] L;
  logic          GS;
  logic          evt_valid;
  logic [CW-1:0] evt_code;
  logic          evt_ready;
  logic          ovf;
  logic          ovf_clr;

  key_scan_encoder #(
    .N_KEYS(N), .DB_CYCLES(DB), .REPEAT_EN(REP_EN),
    .REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .rst(rst), .S_n(S_n), .L(L), .GS(GS),
    .evt_valid(evt_valid), .evt_code(evt_code), .evt_ready(evt_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: key is -1 when nothing is pressed.
  int hist[$];
  int exp_q[$];
  int m_stable = -1;
  int m_code   = 0;
  bit m_valid  = 0;
  bit m_ovf    = 0;
  int m_edge   = 0;
  int next_rep = 0;

  function automatic int enc(input logic [N-1:0] s);
    int r = -1;
    for (int i = 0; i < N; i++) if (!s[i]) r = i;
    return r;
  endfunction

  function automatic int hist_back(input int back);
    int idx = hist.size() - back;
    return (idx >= 0) ? hist[idx] : -1;
  endfunction

  always @(posedge clk) begin
    int prev, v;
    bit same, nev, ovf_set;
    if (rst) begin
      hist.delete();
      exp_q.delete();
      m_stable = -1; m_code = 0; m_valid = 0; m_ovf = 0; m_edge = 0; next_rep = 0;
    end else begin
      m_edge++;
      hist.push_back(enc(S_n));
      if (hist.size() > 64) void'(hist.pop_front());
      // New key value is the sample taken 3 edges ago, steady over DB samples.
      prev = m_stable;
      v    = hist_back(4);
      same = 1;
      for (int k = 1; k < DB; k++) if (hist_back(4 + k) != v) same = 0;
      if (same) m_stable = v;
      nev = 0;
      if (m_stable >= 0 && m_stable != prev) begin
        nev = 1; next_rep = m_edge + DELAY;
      end else if (m_stable >= 0 && REP_EN != 0 && m_edge == next_rep) begin
        nev = 1; next_rep = m_edge + PERIOD;
      end
      ovf_set = 0;
      if (nev) begin
        if (!m_valid || evt_ready) begin
          m_valid = 1; m_code = m_stable; exp_q.push_back(m_stable);
        end else ovf_set = 1;
      end else if (m_valid && evt_ready) m_valid = 0;
      m_ovf = ovf_set ? 1'b1 : (ovf_clr ? 1'b0 : m_ovf);
    end
  end

  // Output checker and scoreboard monitor.
  always @(negedge clk) begin
    chk("L", int'(L), (m_stable < 0) ? 0 : m_stable);
    chk("GS", int'(GS), (m_stable >= 0) ? 1 : 0);
    chk("evt_valid", int'(evt_valid), int'(m_valid));
    chk("ovf", int'(ovf), int'(m_ovf));
    if (m_valid) chk("evt_code_hold", int'(evt_code), m_code);
    if (!rst && evt_valid && evt_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL evt_pop: got code %0d, expected no event at t=%0t", evt_code, $time);
      end else chk("evt_pop", int'(evt_code), exp_q.pop_front());
    end
  end

  task automatic hold(input logic [N-1:0] s, input int n);
    repeat (n) begin
      @(posedge clk); #1;
      S_n = s;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  initial begin
    int k;
    bit found;
    logic [N-1:0] pat;
    rst = 1'b1; S_n = '1; evt_ready = 1'b1; ovf_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold('1, 10);

    // Single press: latency to L/GS and event.
    @(posedge clk); #1 S_n = 10'b1111011111;
    found = 0; k = 0;
    while (!found && k < 20) begin
      @(posedge clk); #1; k++;
      if (GS && evt_valid) found = 1;
    end
    chk("press_latency", k, DB + 3);
    hold(10'b1111011111, 10);
    hold('1, 15);

    // Bounce on key 3 then steady.
    for (int i = 0; i < 6; i++) begin
      hold(10'b1111110111, 2);
      hold('1, 2);
    end
    hold(10'b1111110111, 15);
    hold('1, 15);

    // Priority: keys 2 and 8, then key 8 released.
    hold(10'b1011111011, 15);
    hold(10'b1111111011, 15);
    hold('1, 15);

    // Repeat on key 9.
    hold(10'b0111111111, 70);
    hold('1, 30);

    // Backpressure and overflow.
    evt_ready = 1'b0;
    hold(10'b1111101111, 12);
    hold('1, 12);
    hold(10'b1110111111, 12);
    hold('1, 12);
    evt_ready = 1'b1;
    hold('1, 3);
    ovf_clr = 1'b1;
    hold('1, 1);
    ovf_clr = 1'b0;
    hold('1, 5);

    // Reset while repeating on key 7.
    hold(10'b1101111111, 40);
    rst = 1'b1;
    hold(10'b1101111111, 2);
    rst = 1'b0;
    hold(10'b1101111111, 20);
    hold('1, 15);

    // Randomised traffic.
    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 3))
        0: pat = '1;
        1: begin pat = '1; pat[$urandom_range(0, N-1)] = 1'b0; end
        default: begin
          pat = '1;
          pat[$urandom_range(0, N-1)] = 1'b0;
          pat[$urandom_range(0, N-1)] = 1'b0;
        end
      endcase
      for (int c = 0; c < $urandom_range(1, 45); c++) begin
        @(posedge clk); #1;
        S_n = pat;
        if ($urandom_range(0, 7) == 0) S_n[$urandom_range(0, N-1)] = ~pat[0];
        evt_ready = ($urandom_range(0, 9) < 7);
        ovf_clr   = ($urandom_range(0, 9) == 0);
        rst       = ($urandom_range(0, 299) == 0);
      end
    end

    rst = 1'b0; evt_ready = 1'b1; ovf_clr = 1'b0;
    hold('1, 30);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
